aes_reg_round: RTL and testbench

//   One registered AES-128 encryption round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
//   The result is captured on the rising clock edge.

---
 rtl/aes_reg_round_if.sv | 32 +++
 rtl/aes_reg_round.sv | 132 +++++++++++++
 tb/tb_aes_reg_round.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_reg_round_if.sv
// -----------------------------------------------------------------------------
// aes_reg_round_if
//   Bundles the datapath signals of one registered AES-128 round so that the
//   round and whoever feeds it can be wired with a single connection.
//
//   Signals
//     data_in   128  input state, byte0 = data_in[127:120] ... byte15 = data_in[7:0]
//     key_in    128  round key, same byte ordering as data_in
//     data_out  128  registered round result
//     is_final    1  final-round select, present only with AES_FINAL_ROUND_EN
//
//   Modports
//     master    drives data_in/key_in(/is_final), observes data_out
//     slave     the round itself: consumes inputs, drives data_out
//
//   Configuration macro: AES_FINAL_ROUND_EN adds the is_final signal.
// -----------------------------------------------------------------------------
interface aes_reg_round_if;
   logic [127:0] data_in;
   logic [127:0] key_in;
   logic [127:0] data_out;

`ifdef AES_FINAL_ROUND_EN
   logic         is_final;

   modport master (output data_in, output key_in, output is_final, input data_out);
   modport slave  (input data_in, input key_in, input is_final, output data_out);
`else
   modport master (output data_in, output key_in, input data_out);
   modport slave  (input data_in, input key_in, output data_out);
`endif
endinterface

// File: rtl/aes_reg_round.sv
// -----------------------------------------------------------------------------
// aes_reg_round
//   One registered AES-128 encryption round:
//     data_out <= MixColumns(ShiftRows(SubBytes(data_in))) ^ key_in
//   All round logic is combinational and feeds a single 128-bit register
//   that loads on every rising edge of CLK (latency exactly one cycle).
//
//   Ports
//     CLK   in   1            clock, rising-edge active
//     RST   in   1            synchronous active-high reset, clears data_out
//     bus   aes_reg_round_if.slave
//             data_in  128    input state (byte0 in the MSBs)
//             key_in   128    round key
//             data_out 128    registered round result
//             is_final   1    (AES_FINAL_ROUND_EN only) skip MixColumns
//
//   Configuration macro: AES_FINAL_ROUND_EN
//     defined     : is_final=1 bypasses MixColumns (the last AES round).
//     not defined : MixColumns is always applied.
//
//   State layout is column-major: byte i sits at row i%4, column i/4.
// -----------------------------------------------------------------------------
module aes_reg_round (
   input  logic          CLK,
   input  logic          RST,
   aes_reg_round_if.slave bus
);

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   // General GF(2^8) multiply, shift-and-add over the bits of b.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 (Fermat), built from a short
   // square-and-multiply chain. 0 maps to 0, which is what the S-box needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a240, a252;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a6   = gf_mul(a3, a3);
      a12  = gf_mul(a6, a6);
      a15  = gf_mul(a12, a3);
      a240 = gf_mul(a15, a15);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      a252 = gf_mul(a240, a12);
      return gf_mul(a252, a2);
   endfunction

   // S-box = affine transform of the inverse: x ^ rotl1..rotl4 ^ 0x63.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gf_inv(a);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
               ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   logic [127:0] sb_state;
   logic [127:0] sr_state;
   logic [127:0] mc_state;
   logic [127:0] round_out;

   // SubBytes: sixteen independent S-box instances, one per state byte.
   always_comb begin
      sb_state = '0;
      for (int i = 0; i < 16; i++) begin
         sb_state[127 - 8*i -: 8] = sbox(bus.data_in[127 - 8*i -: 8]);
      end
   end

   // ShiftRows: byte at (row r, column c) takes the byte from column
   // (c + r) mod 4 of the same row, i.e. row r rotates left by r.
   always_comb begin
      sr_state = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            sr_state[127 - 8*(r + 4*c) -: 8] =
               sb_state[127 - 8*(r + 4*((c + r) % 4)) -: 8];
         end
      end
   end

   // MixColumns: each column times the circulant {02 03 01 01}; the 03
   // term is written as xtime(a) ^ a so only xtime is needed here.
   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      mc_state = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = sr_state[127 - 32*c      -: 8];
         a1 = sr_state[127 - 32*c - 8  -: 8];
         a2 = sr_state[127 - 32*c - 16 -: 8];
         a3 = sr_state[127 - 32*c - 24 -: 8];
         mc_state[127 - 32*c      -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
         mc_state[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
         mc_state[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
         mc_state[127 - 32*c - 24 -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      end
   end

   // AddRoundKey, with the optional MixColumns bypass for the last round.
   always_comb begin
`ifdef AES_FINAL_ROUND_EN
      round_out = (bus.is_final ? sr_state : mc_state) ^ bus.key_in;
`else
      round_out = mc_state ^ bus.key_in;
`endif
   end

   // Output register: loads every edge, reset takes priority over the load.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.data_out <= 128'h0;
      end else begin
         bus.data_out <= round_out;
      end
   end

endmodule

// File: tb/tb_aes_reg_round.sv
// -----------------------------------------------------------------------------
// tb_aes_reg_round
//   Self-checking bench for aes_reg_round. Inputs change on the falling edge,
//   data_out is sampled 3 ns after each rising edge. Expected values are
//   either known-answer constants or come from a byte-matrix AES round model
//   whose S-box table is built by brute-force inverse search.
//   Honours AES_FINAL_ROUND_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_aes_reg_round;

   logic CLK;
   logic RST;

   aes_reg_round_if bus ();

   aes_reg_round dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cmp_cnt  = 0;
   int fail_cnt = 0;

   logic [7:0] sbox_tbl [256];

   // Peasant GF(2^8) multiply used only to build the S-box table.
   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 0; x = a; y = b;
      while (y != 0) begin
         if (y[0]) p = p ^ x;
         x = (x[7]) ? ((x << 1) ^ 8'h1B) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Build the S-box: search the inverse, then apply the bitwise affine map
   // b_i = x_i ^ x_(i+4) ^ x_(i+5) ^ x_(i+6) ^ x_(i+7) ^ c_i, c = 0x63.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] s;
      c = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (tb_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                 ^ inv[(i+7)%8] ^ c[i];
         end
         sbox_tbl[a] = s;
      end
   endtask

   function automatic logic [7:0] mul2(input logic [7:0] a);
      return tb_gmul(a, 8'h02);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] a);
      return tb_gmul(a, 8'h03);
   endfunction

   // Reference round on a 4x4 byte matrix [row][col].
   function automatic logic [127:0] model_round(input logic [127:0] d,
                                                input logic [127:0] k,
                                                input bit fin);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   m [4][4];
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i%4][i/4] = sbox_tbl[d[127-8*i -: 8]];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r][c] = s[r][(c+r)%4];
      for (int c = 0; c < 4; c++) begin
         m[0][c] = mul2(t[0][c]) ^ mul3(t[1][c]) ^ t[2][c] ^ t[3][c];
         m[1][c] = t[0][c] ^ mul2(t[1][c]) ^ mul3(t[2][c]) ^ t[3][c];
         m[2][c] = t[0][c] ^ t[1][c] ^ mul2(t[2][c]) ^ mul3(t[3][c]);
         m[3][c] = mul3(t[0][c]) ^ t[1][c] ^ t[2][c] ^ mul2(t[3][c]);
      end
      for (int i = 0; i < 16; i++)
         res[127-8*i -: 8] = (fin ? t[i%4][i/4] : m[i%4][i/4]) ^ k[127-8*i -: 8];
      return res;
   endfunction

   // Drive one set of inputs on the falling edge.
   task automatic apply_stimulus(input logic rst, input logic [127:0] d,
                                 input logic [127:0] k, input bit fin);
      @(negedge CLK);
      RST         = rst;
      bus.data_in = d;
      bus.key_in  = k;
`ifdef AES_FINAL_ROUND_EN
      bus.is_final = fin;
`endif
   endtask

   // Compare data_out against an expected value at the current time.
   task automatic check_output(input string tag, input logic [127:0] exp);
      cmp_cnt++;
      assert (bus.data_out === exp)
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, bus.data_out, exp);
      end
   endtask

   // Apply, take one rising edge, sample 3 ns later and check.
   task automatic step(input string tag, input logic rst, input logic [127:0] d,
                       input logic [127:0] k, input bit fin, input logic [127:0] exp);
      apply_stimulus(rst, d, k, fin);
      @(posedge CLK);
      #3;
      check_output(tag, exp);
   endtask

   localparam logic [127:0] KEY_62 = 128'h63636362_63636362_63636362_63636362;

   initial begin
      logic [127:0] d, k, exp_val;
      logic         r;
      bit           f;

      RST         = 1'b1;
      bus.data_in = '0;
      bus.key_in  = '0;
`ifdef AES_FINAL_ROUND_EN
      bus.is_final = 1'b0;
`endif
      build_sbox();

      // Reset for two edges with arbitrary data present.
      step("reset_edge1", 1'b1, {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0);
      step("reset_edge2", 1'b1, {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0);

      // Known answers.
      step("zero_state", 1'b0, 128'h0, 128'h0, 1'b0,
           128'h63636363_63636363_63636363_63636363);
      step("zero_key62", 1'b0, 128'h0, KEY_62, 1'b0,
           128'h00000001_00000001_00000001_00000001);
      step("byte15_0a", 1'b0, 128'h0A, KEY_62, 1'b0,
           128'h04040C09_00000001_00000001_00000001);

      // Output must hold between edges even though inputs change.
      apply_stimulus(1'b0, 128'h0, 128'h0, 1'b0);
      #3;
      check_output("hold_between_edges", 128'h04040C09_00000001_00000001_00000001);
      @(posedge CLK);
      #3;
      check_output("load_after_edge", 128'h63636363_63636363_63636363_63636363);
      #4;
      check_output("stable_late_cycle", 128'h63636363_63636363_63636363_63636363);

      // Reset wins over valid data, then the first released edge loads.
      step("reset_priority", 1'b1, 128'h0A, KEY_62, 1'b0, 128'h0);
      step("reset_release", 1'b0, 128'h0A, KEY_62, 1'b0,
           128'h04040C09_00000001_00000001_00000001);

      // FIPS-197 Appendix B, round 1.
      step("fips_round1", 1'b0, 128'h193DE3BE_A0F4E22B_9AC68D2A_E9F84808,
           128'hA0FAFE17_88542CB1_23A33939_2A6C7605, 1'b0,
           128'hA49C7FF2_689F352B_6B5BEA43_026A5049);

`ifdef AES_FINAL_ROUND_EN
      step("final_bypass", 1'b0, 128'h0A, 128'h0, 1'b1,
           128'h63636367_63636363_63636363_63636363);
      step("final_off", 1'b0, 128'h0A, 128'h0, 1'b0,
           128'h67676F6B_63636363_63636363_63636363);
`endif

      // Random rounds with occasional resets, checked against the model.
      for (int n = 0; n < 40; n++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
         r = ($urandom_range(0, 7) == 0);
`ifdef AES_FINAL_ROUND_EN
         f = $urandom_range(0, 1) == 1;
`else
         f = 1'b0;
`endif
         exp_val = r ? 128'h0 : model_round(d, k, f);
         step("random_round", r, d, k, f, exp_val);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
